cpu_reset_seq: RTL and testbench

Parametrised successor to the DCLO/ACLO power-on generator that feeds the VM1 CPU core.
- Provides the full PDP-11 power sequence:
  - Power-up: DCLO released first, then ACLO.
  - Power-down: ACLO asserted ahead of DCLO, so the CPU can take its power-fail trap.
- Debounces the reset button, synchronises the hold request (PLL-unlocked / system-not-ready), and exposes sequencer state.
- Sits between the user_io/PLL status signals and the CPU's `vm_dclo`/`vm_aclo` inputs.

---
 rtl/cpu_reset_seq.sv | 150 +++++++++++++++
 tb/tb_cpu_reset_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_reset_seq.sv
// DCLO/ACLO power sequencer for the VM1 core: debounced button, synchronised hold,
// optional run-state watchdog enabled by defining CPU_RESET_WDOG_EN.
module cpu_reset_seq #(
   parameter int DCLO_CLK     = 24,
   parameter int ACLO_CLK     = 240,
   parameter int PFAIL_CLK    = 48,
   parameter int DEBOUNCE_CLK = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int WDOG_CLK     = 1048576
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       button,
   input  logic       hold,
   input  logic       wdog_kick,
   output logic       dclo,
   output logic       aclo,
   output logic       running,
   output logic [2:0] state,
   output logic       wdog_trip
);

   localparam int MAX_T = (DCLO_CLK > ACLO_CLK) ?
                          ((DCLO_CLK > PFAIL_CLK) ? DCLO_CLK : PFAIL_CLK) :
                          ((ACLO_CLK > PFAIL_CLK) ? ACLO_CLK : PFAIL_CLK);
   localparam int CW  = $clog2(MAX_T) + 1;
   localparam int DBW = $clog2(DEBOUNCE_CLK) + 1;

   localparam logic [CW-1:0]  DCLO_TERM  = CW'(DCLO_CLK - 1);
   localparam logic [CW-1:0]  ACLO_TERM  = CW'(ACLO_CLK - 1);
   localparam logic [CW-1:0]  PFAIL_TERM = CW'(PFAIL_CLK - 1);
   localparam logic [DBW-1:0] DB_TERM    = DBW'(DEBOUNCE_CLK - 1);

   typedef enum logic [2:0] {
      S_HOLD      = 3'd0,
      S_DCLO_WAIT = 3'd1,
      S_ACLO_WAIT = 3'd2,
      S_RUN       = 3'd3,
      S_PFAIL     = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] btn_sync;
   logic [SYNC_STAGES-1:0] hold_sync;
   logic                   btn_s;
   logic                   btn_f;
   logic [DBW-1:0]         db_cnt;
   logic                   req;

   state_t                 st;
   state_t                 nxt;
   logic [CW-1:0]          cnt;
   logic                   timed;
   logic                   expire;

   assign btn_s = btn_sync[SYNC_STAGES-1];
   assign req   = btn_f | hold_sync[SYNC_STAGES-1];
   assign state = st;

   // Synchronisers power up asserted so the CPU stays in reset until inputs settle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_sync  <= '1;
         hold_sync <= '1;
         btn_f     <= 1'b1;
         db_cnt    <= '0;
      end else begin
         btn_sync  <= {btn_sync[SYNC_STAGES-2:0], button};
         hold_sync <= {hold_sync[SYNC_STAGES-2:0], hold};
         if (btn_s == btn_f) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_TERM) begin
            btn_f  <= btn_s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      nxt = st;
      case (st)
         S_HOLD:      if (!req) nxt = S_DCLO_WAIT;
         S_DCLO_WAIT: if (req) nxt = S_HOLD;
                      else if (cnt == DCLO_TERM) nxt = S_ACLO_WAIT;
         S_ACLO_WAIT: if (req) nxt = S_HOLD;
                      else if (cnt == ACLO_TERM) nxt = S_RUN;
         S_RUN:       if (req || expire) nxt = S_PFAIL;
         S_PFAIL:     if (cnt == PFAIL_TERM) nxt = S_HOLD;
         default:     nxt = req ? S_HOLD : S_DCLO_WAIT;
      endcase
   end

   // Only the three timed states count; HOLD and RUN park the counter at zero.
   assign timed = (st == S_DCLO_WAIT) || (st == S_ACLO_WAIT) || (st == S_PFAIL);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st      <= S_HOLD;
         cnt     <= '0;
         dclo    <= 1'b1;
         aclo    <= 1'b1;
         running <= 1'b0;
      end else begin
         st      <= nxt;
         cnt     <= (timed && (nxt == st)) ? cnt + 1'b1 : '0;
         dclo    <= (nxt == S_HOLD) || (nxt == S_DCLO_WAIT);
         aclo    <= (nxt != S_RUN);
         running <= (nxt == S_RUN);
      end
   end

`ifdef CPU_RESET_WDOG_EN
   localparam int            WW      = $clog2(WDOG_CLK) + 1;
   localparam logic [WW-1:0] WD_TERM = WW'(WDOG_CLK - 1);

   logic [WW-1:0] wd_cnt;
   logic          btn_seen;
   logic          leave_hold;

   assign expire     = (st == S_RUN) && !wdog_kick && (wd_cnt == WD_TERM);
   assign leave_hold = (st == S_HOLD) && (nxt != S_HOLD);

   // The trip flag survives automatic restarts; only an operator button press clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt    <= '0;
         btn_seen  <= 1'b0;
         wdog_trip <= 1'b0;
      end else begin
         wd_cnt <= ((st == S_RUN) && (nxt == S_RUN) && !wdog_kick) ? wd_cnt + 1'b1 : '0;
         if (expire)
            wdog_trip <= 1'b1;
         else if (leave_hold && btn_seen)
            wdog_trip <= 1'b0;
         if (leave_hold)
            btn_seen <= 1'b0;
         else if (btn_f)
            btn_seen <= 1'b1;
      end
   end
`else
   logic unused_wdog;

   assign expire      = 1'b0;
   assign wdog_trip   = 1'b0;
   assign unused_wdog = wdog_kick | (WDOG_CLK < 1);
`endif

endmodule

// File: tb/tb_cpu_reset_seq.sv
// Bench for cpu_reset_seq: directed power sequences plus random button/hold/kick traffic
// compared each cycle against a timestamp-based model of the sequencing rules.
module tb_cpu_reset_seq;

   localparam int DCLO_CLK     = 4;
   localparam int ACLO_CLK     = 8;
   localparam int PFAIL_CLK    = 3;
   localparam int DEBOUNCE_CLK = 2;
   localparam int SYNC_STAGES  = 2;
   localparam int WDOG_CLK     = 16;

   localparam int P_HOLD = 0;
   localparam int P_DW   = 1;
   localparam int P_AW   = 2;
   localparam int P_RUN  = 3;
   localparam int P_PF   = 4;

`ifdef CPU_RESET_WDOG_EN
   localparam bit WDOG_ON = 1'b1;
`else
   localparam bit WDOG_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       button = 1'b0;
   logic       hold = 1'b0;
   logic       wdog_kick = 1'b0;
   logic       dclo;
   logic       aclo;
   logic       running;
   logic [2:0] state;
   logic       wdog_trip;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] exp_q[$];

   // model: absolute edge numbers since reset release and entry timestamps
   int m_edge;
   bit raw_b[$];
   bit raw_h[$];
   int m_phase;
   int m_entry;
   int m_wref;
   bit m_btnf;
   bit m_trip;
   bit m_seen;

   cpu_reset_seq #(
      .DCLO_CLK    (DCLO_CLK),
      .ACLO_CLK    (ACLO_CLK),
      .PFAIL_CLK   (PFAIL_CLK),
      .DEBOUNCE_CLK(DEBOUNCE_CLK),
      .SYNC_STAGES (SYNC_STAGES),
      .WDOG_CLK    (WDOG_CLK)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .button   (button),
      .hold     (hold),
      .wdog_kick(wdog_kick),
      .dclo     (dclo),
      .aclo     (aclo),
      .running  (running),
      .state    (state),
      .wdog_trip(wdog_trip)
   );

   // ---------------- clock / timeout ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      n_bad++;
      $display("FAIL timeout: got no finish, required finish before 1ms");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit synced(input int n, input bit is_btn);
      int k;
      k = n - SYNC_STAGES;
      if (k < 1) return 1'b1;
      return is_btn ? raw_b[k-1] : raw_h[k-1];
   endfunction

   task automatic model_reset();
      m_edge  = 0;
      raw_b.delete();
      raw_h.delete();
      m_phase = P_HOLD;
      m_entry = 0;
      m_wref  = 0;
      m_btnf  = 1'b1;
      m_trip  = 1'b0;
      m_seen  = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_edge(input bit b, input bit h, input bit k);
      int nxt;
      int el;
      bit req;
      bit expire;
      bit flip;
      bit e_dclo;
      bit e_aclo;
      bit e_run;
      m_edge++;
      raw_b.push_back(b);
      raw_h.push_back(h);
      req    = m_btnf | synced(m_edge, 1'b0);
      el     = m_edge - m_entry;
      expire = WDOG_ON && (m_phase == P_RUN) && !k && (m_edge - m_wref == WDOG_CLK);
      nxt    = m_phase;
      case (m_phase)
         P_HOLD:  if (!req) nxt = P_DW;
         P_DW:    if (req) nxt = P_HOLD; else if (el == DCLO_CLK) nxt = P_AW;
         P_AW:    if (req) nxt = P_HOLD; else if (el == ACLO_CLK) nxt = P_RUN;
         P_RUN:   if (req || expire) nxt = P_PF;
         default: if (el == PFAIL_CLK) nxt = P_HOLD;
      endcase
      if (expire) m_trip = 1'b1;
      else if (m_phase == P_HOLD && nxt != P_HOLD && m_seen) m_trip = 1'b0;
      if (m_phase == P_HOLD && nxt != P_HOLD) m_seen = 1'b0;
      else if (m_btnf) m_seen = 1'b1;
      if (m_phase == P_RUN && k) m_wref = m_edge;
      if (nxt != m_phase) begin
         m_entry = m_edge;
         m_wref  = m_edge;
      end
      // filtered button flips once the last DEBOUNCE_CLK synced samples all disagree
      flip = 1'b1;
      for (int i = 0; i < DEBOUNCE_CLK; i++)
         if (synced(m_edge - i, 1'b1) == m_btnf) flip = 1'b0;
      if (flip) m_btnf = !m_btnf;
      m_phase = nxt;
      e_dclo  = (m_phase == P_HOLD) || (m_phase == P_DW);
      e_aclo  = (m_phase != P_RUN);
      e_run   = (m_phase == P_RUN);
      exp_q.push_back({3'(m_phase), e_dclo, e_aclo, e_run, m_trip});
   endtask

   // ---------------- drivers (called just after a negedge) ----------------
   task automatic step(input bit b, input bit h, input bit k);
      logic [6:0] e;
      button    = b;
      hold      = h;
      wdog_kick = k;
      @(posedge clk);
      model_edge(b, h, k);
      #1;
      e = exp_q.pop_front();
      check($sformatf("cycle%0d {state,dclo,aclo,run,trip}", m_edge),
            {25'd0, state, dclo, aclo, running, wdog_trip}, {25'd0, e});
      @(negedge clk);
   endtask

   task automatic run_until(input int ph, input int budget);
      int c;
      c = 0;
      while (m_phase != ph && c < budget) begin
         step(1'b0, 1'b0, 1'b0);
         c++;
      end
      check($sformatf("reach_state%0d", ph), {29'd0, state}, ph);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int mode;
      int len;

      // reset values, with noisy inputs while reset is held
      reset_n = 1'b0;
      button  = 1'b1;
      hold    = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", {25'd0, state, dclo, aclo, running, wdog_trip}, 32'b000_1100);
      button = 1'b0;
      hold   = 1'b0;
      release_reset();

      // power-up timing
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (i == 4)  check("pu_e4_state", {29'd0, state}, 0);
         if (i == 5)  check("pu_e5_state", {29'd0, state}, 1);
         if (i == 8)  check("pu_e8_dclo", {31'd0, dclo}, 1);
         if (i == 9)  check("pu_e9_dclo", {31'd0, dclo}, 0);
         if (i == 9)  check("pu_e9_state", {29'd0, state}, 2);
         if (i == 16) check("pu_e16_aclo", {31'd0, aclo}, 1);
         if (i == 17) check("pu_e17_aclo", {31'd0, aclo}, 0);
         if (i == 17) check("pu_e17_running", {31'd0, running}, 1);
      end

      // button press in RUN held 10 cycles, then release and re-power
      for (int i = 1; i <= 40; i++) begin
         step(i <= 10, 1'b0, (i % 10) == 0);
         if (i == 4) check("btn_e4_aclo", {31'd0, aclo}, 0);
         if (i == 5) check("btn_e5_aclo", {31'd0, aclo}, 1);
         if (i == 5) check("btn_e5_state", {29'd0, state}, 4);
         if (i == 7) check("btn_e7_dclo", {31'd0, dclo}, 0);
         if (i == 8) check("btn_e8_dclo", {31'd0, dclo}, 1);
         if (i == 8) check("btn_e8_state", {29'd0, state}, 0);
      end
      check("btn_rerun", {31'd0, running}, 1);

      // single-cycle glitch must not disturb RUN
      for (int i = 1; i <= 11; i++) begin
         step(i == 1, 1'b0, (i % 5) == 0);
         check("glitch_state", {29'd0, state}, 3);
      end

      // hold arriving together with the DCLO_WAIT terminal count: hold wins
      for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b0);
      run_until(P_DW, 40);
      step(1'b0, 1'b0, 1'b0);
      for (int j = 1; j <= 4; j++) begin
         step(1'b0, 1'b1, 1'b0);
         if (j == 2) check("hold_j2_state", {29'd0, state}, 1);
         if (j == 3) check("hold_j3_state", {29'd0, state}, 0);
         if (j == 3) check("hold_j3_dclo", {31'd0, dclo}, 1);
      end

      // asynchronous reset in ACLO_WAIT
      run_until(P_AW, 40);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_state", {29'd0, state}, 0);
      check("async_dclo", {31'd0, dclo}, 1);
      check("async_aclo", {31'd0, aclo}, 1);
      check("async_running", {31'd0, running}, 0);
      @(posedge clk);
      release_reset();

      run_until(P_RUN, 60);
`ifdef CPU_RESET_WDOG_EN
      for (int i = 1; i <= 60; i++) begin
         step(1'b0, 1'b0, (i % 10) == 0);
         check("wdog_kicked_running", {31'd0, running}, 1);
      end
      for (int i = 1; i <= 19; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (i == 15) check("wdog_i15_state", {29'd0, state}, 3);
         if (i == 16) check("wdog_i16_state", {29'd0, state}, 4);
         if (i == 16) check("wdog_i16_trip", {31'd0, wdog_trip}, 1);
         if (i == 18) check("wdog_i18_dclo", {31'd0, dclo}, 0);
         if (i == 19) check("wdog_i19_dclo", {31'd0, dclo}, 1);
      end
`else
      for (int i = 1; i <= 60; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if ((i % 10) == 0) check("nowdog_running", {31'd0, running}, 1);
      end
`endif

      // randomized traffic
      for (int s = 0; s < 70; s++) begin
         mode = $urandom_range(0, 9);
         if (mode <= 4) begin
            len = $urandom_range(10, 40);
            for (int i = 0; i < len; i++) step(1'b0, 1'b0, $urandom_range(0, 7) == 0);
         end else if (mode <= 6) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) step(1'b1, 1'b0, $urandom_range(0, 7) == 0);
         end else if (mode <= 8) begin
            len = $urandom_range(1, 15);
            for (int i = 0; i < len; i++) step(1'b0, 1'b1, $urandom_range(0, 7) == 0);
         end else begin
            for (int i = 0; i < 8; i++)
               step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
